adder_arbiter: RTL

Shares one combinational WIDTH-bit carry-lookahead adder (fa4/cla chain) between two requesters, e.g. the ALU address path and the HI/LO multiply-accumulate path. Arbitrates round-robin with a valid/ready handshake and sequences each granted operation through the shared adder. With the double-width option it runs 2*WIDTH-bit additions as two adder passes chained through a registered carry. Results return on per-requester one-cycle response pulses.

---
 rtl/adder_arbiter_if.sv | 48 ++++
 rtl/adder_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request, response and shared-adder signals of adder_arbiter.
// master = requesters plus the external adder (bench side); slave = the arbiter.
interface adder_arbiter_if #(
  parameter int WIDTH = 32
);
  logic               req0_valid;
  logic               req0_ready;
  logic [2*WIDTH-1:0] req0_a;
  logic [2*WIDTH-1:0] req0_b;
  logic               req0_cin;
  logic               req0_dbl;

  logic               req1_valid;
  logic               req1_ready;
  logic [2*WIDTH-1:0] req1_a;
  logic [2*WIDTH-1:0] req1_b;
  logic               req1_cin;
  logic               req1_dbl;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;

  logic               rsp0_valid;
  logic               rsp1_valid;
  logic [2*WIDTH-1:0] rsp_sum;
  logic               rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_dbl,
    output req1_valid, req1_a, req1_b, req1_cin, req1_dbl,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout,
    input  rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_dbl,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_dbl,
    output req0_ready, req1_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout,
    output rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external WIDTH-bit adder between two
// requesters. Each accepted op runs LO (and HI for double width) passes through
// the adder, then pulses rsp<id>_valid for one cycle in DONE.
// Optional feature: define ADDER_ARB_DBL_EN to build the HI pass and 2*WIDTH-bit
// adds; without it req*_dbl is ignored and every op is WIDTH bits wide.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  adder_arbiter_if.slave bus
);

`ifdef ADDER_ARB_DBL_EN
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam bit DblEn = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, LO, DONE} state_t;
  localparam bit DblEn = 1'b0;
`endif

  state_t             state;
  state_t             state_nxt;

  logic               last_grant;
  logic               op_id;
  logic [2*WIDTH-1:0] op_a;
  logic [2*WIDTH-1:0] op_b;
  logic               op_cin;
  logic               op_dbl;
  logic [2*WIDTH-1:0] sum;
  logic               carry;

  logic               grant0;
  logic               grant1;
  logic               in_idle;
  logic               accept;

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    grant0         = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1         = bus.req1_valid && (!bus.req0_valid || !last_grant);
    in_idle        = (state == IDLE) && !rst;
    bus.req0_ready = in_idle && grant0;
    bus.req1_ready = in_idle && grant1;
    accept         = in_idle && (grant0 || grant1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, shared-adder operand steering and response pulses.
  always_comb begin
    state_nxt      = state;
    bus.add_a      = '0;
    bus.add_b      = '0;
    bus.add_cin    = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LO;
      end
      LO: begin
        bus.add_a   = op_a[WIDTH-1:0];
        bus.add_b   = op_b[WIDTH-1:0];
        bus.add_cin = op_cin;
        state_nxt   = DONE;
`ifdef ADDER_ARB_DBL_EN
        if (op_dbl) state_nxt = HI;
`endif
      end
`ifdef ADDER_ARB_DBL_EN
      HI: begin
        bus.add_a   = op_a[2*WIDTH-1:WIDTH];
        bus.add_b   = op_b[2*WIDTH-1:WIDTH];
        bus.add_cin = carry;
        state_nxt   = DONE;
      end
`endif
      DONE: begin
        bus.rsp0_valid = !op_id;
        bus.rsp1_valid = op_id;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept and result/carry capture after each adder pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_dbl     <= 1'b0;
      sum        <= '0;
      carry      <= 1'b0;
    end else begin
      if (accept) begin
        op_id      <= !grant0;
        last_grant <= !grant0;
        op_a       <= grant0 ? bus.req0_a : bus.req1_a;
        op_b       <= grant0 ? bus.req0_b : bus.req1_b;
        op_cin     <= grant0 ? bus.req0_cin : bus.req1_cin;
        op_dbl     <= DblEn && (grant0 ? bus.req0_dbl : bus.req1_dbl);
      end
      if (state == LO) begin
        sum[WIDTH-1:0] <= bus.add_s;
        carry          <= bus.add_cout;
        if (!op_dbl) sum[2*WIDTH-1:WIDTH] <= '0;
      end
`ifdef ADDER_ARB_DBL_EN
      if (state == HI) begin
        sum[2*WIDTH-1:WIDTH] <= bus.add_s;
        carry                <= bus.add_cout;
      end
`endif
    end
  end

  assign bus.rsp_sum  = sum;
  assign bus.rsp_cout = carry;

endmodule
